// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch stage, ack/data back from memory.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction fetch stage: holds PC, fetches over req/ack, computes next PC on retire.
// Optional macro IFETCH_MISALIGN_TRAP_EN: misaligned next PC enters a sticky fault state.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master imem,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic [5:0]    funct,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  input  logic          retire,
  input  logic [1:0]    jump,
  input  logic [1:0]    branch,
  input  logic          zero,
  input  logic [31:0]   imm32,
  input  logic [31:0]   rs_data,
  output logic [31:0]   retired_cnt,
  output logic          fault
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] next_pc_raw, next_pc;
  logic        br_taken, misalign;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    br_taken = ((branch == 2'b01) && zero) || ((branch == 2'b10) && !zero);
    case (jump)
      2'b01, 2'b10: next_pc_raw = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b11:        next_pc_raw = rs_data;
      default:      next_pc_raw = br_taken ? (pc_plus4 + (imm32 << 2)) : pc_plus4;
    endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
    next_pc  = next_pc_raw;
    misalign = |next_pc_raw[1:0];
`else
    // Only jr can produce a misaligned target; without the trap it is silently aligned.
    next_pc  = next_pc_raw & ~32'h3;
    misalign = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem.imem_ack) state_d = S_VALID;
      S_VALID: if (retire) state_d = misalign ? S_FAULT : S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_d    = (state_d == S_FETCH);
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    retired_cnt_d = retired_cnt_q;
    if ((state_q == S_FETCH) && imem.imem_ack) begin
      instr_d       = imem.imem_rdata;
      instr_valid_d = 1'b1;
    end
    if ((state_q == S_VALID) && retire) begin
      pc_d          = next_pc;
      instr_valid_d = 1'b0;
      retired_cnt_d = retired_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req_q    <= 1'b0;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      retired_cnt_q <= 32'h0;
    end else begin
      imem_req_q    <= imem_req_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign fault_d = fault_q | ((state_q == S_VALID) && retire && misalign);

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign funct          = instr_q[5:0];
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign retired_cnt    = retired_cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed fetch/retire sequences checked against a behavioural model.
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, pc_plus4, retired_cnt, imm32, rs_data;
  logic [5:0]  opcode, funct;
  logic        instr_valid, retire, zero, fault;
  logic [1:0]  jump, branch;

  ifetch_unit_if imem ();

  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .retire(retire), .jump(jump), .branch(branch),
    .zero(zero), .imm32(imm32), .rs_data(rs_data), .retired_cnt(retired_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 fetching, 2 holding instruction, 3 faulted.
  int          m_ph;
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_valid, m_req, m_fault;
  logic        preload = 1'b0;
  logic        chk_en  = 1'b0;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ir,
                                           input logic [1:0] j, input logic [1:0] br,
                                           input logic z, input logic [31:0] imm,
                                           input logic [31:0] rs);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j == 2'd1 || j == 2'd2) return (seq & 32'hF000_0000) | ((ir % 32'h0400_0000) * 4);
    if (j == 2'd3) return rs;
    if ((br == 2'd1 && z) || (br == 2'd2 && !z)) return seq + imm * 4;
    return seq;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_pc <= RPC; m_instr <= 32'h0; m_valid <= 1'b0;
      m_cnt <= 32'h0; m_req <= 1'b0; m_fault <= 1'b0;
    end else begin
      case (m_ph)
        0: begin m_ph <= 1; m_req <= 1'b1; end
        1: if (imem.imem_ack) begin
             m_instr <= imem.imem_rdata; m_valid <= 1'b1; m_req <= 1'b0; m_ph <= 2;
           end
        2: if (retire) begin
             m_valid <= 1'b0;
             m_cnt   <= (preload ? 32'hFFFF_FFFF : m_cnt) + 32'd1;
`ifdef IFETCH_MISALIGN_TRAP_EN
             m_pc <= ref_next(m_pc, m_instr, jump, branch, zero, imm32, rs_data);
             if (ref_next(m_pc, m_instr, jump, branch, zero, imm32, rs_data) % 4 != 0) begin
               m_fault <= 1'b1; m_ph <= 3;
             end else begin
               m_req <= 1'b1; m_ph <= 1;
             end
`else
             m_pc  <= ref_next(m_pc, m_instr, jump, branch, zero, imm32, rs_data) & ~32'h3;
             m_req <= 1'b1; m_ph <= 1;
`endif
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req", 32'(imem.imem_req), 32'(m_req));
      check("m_addr", imem.imem_addr, m_pc);
      check("m_pc", pc, m_pc);
      check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("m_instr", instr, m_instr);
      check("m_opcode", 32'(opcode), 32'(m_instr >> 26));
      check("m_funct", 32'(funct), m_instr & 32'h3F);
      check("m_valid", 32'(instr_valid), 32'(m_valid));
      check("m_fault", 32'(fault), 32'(m_fault));
      if (!preload) check("m_cnt", retired_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] word, input int dly);
    int n;
    logic [31:0] a;
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin step(); n++; end
    check("req_wait", 32'(imem.imem_req), 32'd1);
    a = imem.imem_addr;
    repeat (dly) begin
      step();
      check("addr_hold", imem.imem_addr, a);
      check("valid_low_wait", 32'(instr_valid), 32'd0);
    end
    imem.imem_ack = 1'b1; imem.imem_rdata = word;
    step();
    imem.imem_ack = 1'b0;
    check("valid_after_ack", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_retire(input logic [1:0] j, input logic [1:0] br, input logic z,
                           input logic [31:0] imm, input logic [31:0] rs);
    jump = j; branch = br; zero = z; imm32 = imm; rs_data = rs; retire = 1'b1;
    step();
    retire = 1'b0; jump = 2'b00; branch = 2'b00;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    fetch(32'h0, 0);
    do_retire(2'b11, 2'b00, 1'b0, 32'h0, a);
  endtask

  initial begin
    rst = 1'b1; retire = 1'b0; jump = 2'b00; branch = 2'b00; zero = 1'b0;
    imm32 = 32'h0; rs_data = 32'h0; imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    step();
    chk_en = 1'b1;
    step(); step();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    rst = 1'b0;
    step();
    check("req_after_idle", 32'(imem.imem_req), 32'd1);
    check("first_addr", imem.imem_addr, 32'h0000_3000);

    fetch(32'h3401_0005, 0);
    check("ori_opcode", 32'(opcode), 32'h0000_000D);
    check("ori_funct", 32'(funct), 32'h0000_0005);
    check("ori_pc", pc, 32'h0000_3000);
    do_retire(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    check("seq_pc", pc, 32'h0000_3004);
    check("cnt_one", retired_cnt, 32'd1);
    check("req_after_retire", 32'(imem.imem_req), 32'd1);

    goto_pc(32'h0000_3010);
    fetch(32'h1000_FFFF, 0);
    do_retire(2'b00, 2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0);
    check("beq_taken", pc, 32'h0000_3004);

    goto_pc(32'h0000_3010);
    fetch(32'h1000_FFFF, 0);
    do_retire(2'b00, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("beq_not_taken", pc, 32'h0000_3014);

    goto_pc(32'h0000_3010);
    fetch(32'h1400_FFFF, 0);
    do_retire(2'b00, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("bne_taken", pc, 32'h0000_3004);

    goto_pc(32'h0000_3020);
    fetch(32'h0800_0C10, 0);
    do_retire(2'b01, 2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0);
    check("j_target", pc, 32'h0000_3040);

    goto_pc(32'h0000_3020);
    fetch(32'h0C00_0C10, 0);
    check("jal_link", pc_plus4, 32'h0000_3024);
    step();
    check("jal_link_held", pc_plus4, 32'h0000_3024);
    do_retire(2'b10, 2'b00, 1'b0, 32'h0, 32'h0);
    check("jal_target", pc, 32'h0000_3040);

    goto_pc(32'h0000_3100);
    check("jr_target", pc, 32'h0000_3100);

    fetch(32'h2000_0001, 5);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem.imem_ack = 1'b0;
    check("spurious_ack_ir", instr, 32'h2000_0001);
    do_retire(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    check("after_wait_pc", pc, 32'h0000_3104);

    fetch(32'h0, 0);
    retire = 1'b1; jump = 2'b00; branch = 2'b00;
    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    preload = 1'b1;
    step();
    retire = 1'b0; preload = 1'b0;
    check("cnt_wrap", retired_cnt, 32'd0);

    check("req_before_rst", 32'(imem.imem_req), 32'd1);
    rst = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1111_1111;
    step();
    rst = 1'b0;
    step();
    imem.imem_ack = 1'b0;
    check("midfetch_rst_pc", pc, 32'h0000_3000);
    check("midfetch_rst_cnt", retired_cnt, 32'd0);
    check("midfetch_ack_ignored", 32'(instr_valid), 32'd0);
    check("midfetch_instr", instr, 32'd0);

    fetch(32'h0380_0008, 0);
    do_retire(2'b11, 2'b00, 1'b0, 32'h0, 32'h0000_3102);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("trap_fault", 32'(fault), 32'd1);
    check("trap_pc", pc, 32'h0000_3102);
    check("trap_cnt", retired_cnt, 32'd1);
    imem.imem_ack = 1'b1;
    repeat (4) begin
      step();
      check("trap_req_low", 32'(imem.imem_req), 32'd0);
      check("trap_valid_low", 32'(instr_valid), 32'd0);
      check("trap_sticky", 32'(fault), 32'd1);
    end
    imem.imem_ack = 1'b0;
`else
    check("align_pc", pc, 32'h0000_3100);
    check("align_fault", 32'(fault), 32'd0);
    check("align_req", 32'(imem.imem_req), 32'd1);
`endif

    rst = 1'b1;
    step();
    check("final_rst_fault", 32'(fault), 32'd0);
    check("final_rst_pc", pc, 32'h0000_3000);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS core, directly upstream of the control decoder. It holds the PC and requests the instruction word from instruction memory over a req/ack handshake. It presents the latched instruction (opcode/funct fields included) to the decoder and datapath. On retire, it computes the next PC from the decoder's jump/branch outputs, the ALU zero flag, the immediate and the rs register value.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction register (IR).
- opcode  out  6  instr[31:26], to decoder OpCode.
- funct  out  6  instr[5:0], to decoder funct.
- instr_valid  out  1  IR holds an unretired instruction.
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc+4; jal link value.
- retire  in  1  datapath finished current instruction; sampled only when instr_valid.
- jump  in  2  decoder jump: 00 none, 01 j, 10 jal, 11 jr.
- branch  in  2  decoder Branch: 01 beq, 10 bne, 00/11 none.
- zero  in  1  ALU zero flag.
- imm32  in  32  extended immediate (sign-extended for branches).
- rs_data  in  32  register rs value for jr.
- retired_cnt  out  32  count of retired instructions.
- fault  out  1  misaligned-target fault (macro-dependent).

## Operation
- FSM states: S_IDLE, S_FETCH, S_VALID, S_FAULT.
- S_IDLE: one cycle after reset, then S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc. On imem_ack: IR<=imem_rdata, instr_valid<=1, go to S_VALID.
- S_VALID: imem_req=0 and IR held. On retire:
  - pc<=next_pc, instr_valid<=0, retired_cnt+=1.
  - Go to S_FETCH, or S_FAULT (see Configuration).
- next_pc priority:
  - jump 01/10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jump 11: rs_data.
  - jump 00 with (branch==01 && zero) or (branch==10 && !zero): pc_plus4 + (imm32<<2), mod 2^32.
  - Otherwise: pc_plus4.
- Non-zero jump overrides branch.
- All additions wrap modulo 2^32; retired_cnt wraps 0xFFFF_FFFF->0.
- imem_ack outside S_FETCH is ignored. retire outside S_VALID is ignored.
- S_FAULT: imem_req=0, instr_valid=0, fault=1. Left only by reset.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_cnt=0, fault=0, state=S_IDLE.
- Reset asserted mid-fetch: an outstanding ack in the next cycle is ignored (state is S_IDLE).
- imem_req rises on the first edge after reset release plus one cycle. First possible IR load is one edge after that, if ack is zero-wait.
- imem_addr is stable while imem_req=1. The memory may hold ack low for any number of cycles.
- Latency is 1 cycle from ack to instr_valid=1. pc updates on the retire edge; imem_req=1 in the following cycle.
- Minimum instruction period: 2 cycles (fetch with zero-wait ack, then retire in the next cycle).
- opcode/funct/pc_plus4 are combinational from registers and are stable for the whole S_VALID interval.

## Configuration
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined: if next_pc[1:0]!=0 on retire (only reachable via jr), then pc<=next_pc, state<=S_FAULT, fault<=1. retired_cnt still increments.
- Undefined: next_pc[1:0] is forced to 00; fault is tied 0; S_FAULT is unreachable.

## Test plan
- Reset, then zero-wait memory returning 0x3401_0005 at 0x3000. Expect imem_req high 1 cycle after S_IDLE, instr_valid next cycle, opcode=6'b001101, pc=0x3000. After retire, pc=0x3004.
- beq at pc=0x3010 with imm32=0xFFFF_FFFC, zero=1 -> pc=0x3004. With zero=0 -> pc=0x3014. bne with zero=0 -> pc=0x3004.
- j with instr=0x0800_0C10 at pc=0x3020 -> pc=0x0000_3040. jal: pc_plus4=0x3024 while valid.
- jr with rs_data=0x0000_3100 -> pc=0x3100. jr with rs_data=0x3102 -> macro defined: fault=1, imem_req stays 0 until rst. Macro undefined: pc=0x3100.
- Ack held low 5 cycles: imem_addr constant and instr_valid=0 throughout. A spurious ack during S_VALID leaves IR unchanged. rst asserted in S_FETCH -> pc=RESET_PC, retired_cnt=0.
- Preload retired_cnt path (force) at 0xFFFF_FFFF, retire once -> 0.
